// File: rtl/wb_port_arbiter_pkg.sv
// ============================================================================
// Module  : wb_port_arbiter_pkg
// Brief   : Shared widths, requester indices and priority-mode encodings.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package wb_port_arbiter_pkg;
    localparam int   c_AW = 5;
    localparam int   c_DW = 32;

    localparam logic c_SRC_ALU = 1'b0;
    localparam logic c_SRC_MEM = 1'b1;

    localparam int   c_PRIO_RR        = 0;
    localparam int   c_PRIO_FIXED_MEM = 1;
endpackage

`default_nettype wire

// File: rtl/wb_port_arbiter_req_buffer.sv
// ============================================================================
// Module  : wb_req_buffer
// Brief   : One-entry valid/ready holding register with clear and flush.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_req_buffer
    import wb_port_arbiter_pkg::*;
#(
    parameter int AW = c_AW,
    parameter int DW = c_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_data,
    output logic          o_ready,
    input  logic          i_flush,
    input  logic          i_clear,
    output logic          o_full,
    output logic [AW-1:0] o_addr,
    output logic [DW-1:0] o_data
);
    logic          r_full;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    logic          w_load;

    assign o_ready = !r_full && !i_flush;
    assign w_load  = i_valid && o_ready;

    // A clear only targets a full entry and a load only an empty one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else begin
            if (i_flush || i_clear) begin
                r_full <= 1'b0;
            end else if (w_load) begin
                r_full <= 1'b1;
            end
            if (w_load) begin
                r_addr <= i_addr;
                r_data <= i_data;
            end
        end
    end

    assign o_full = r_full;
    assign o_addr = r_addr;
    assign o_data = r_data;
endmodule

`default_nettype wire

// File: rtl/wb_port_arbiter.sv
// ============================================================================
// Module  : wb_port_arbiter
// Brief   : Two-source register-file write-port arbiter with registered port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int AW            = c_AW,
    parameter int DW            = c_DW,
    parameter int PRIORITY_MODE = c_PRIO_RR,
    parameter int ZERO_DISCARD  = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    input  logic          stall,
    input  logic          flush,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          wr_sel,
    output logic [15:0]   conflict_cnt
);
    logic          w_full0, w_full1;
    logic [AW-1:0] w_addr0, w_addr1;
    logic [DW-1:0] w_data0, w_data1;
    logic          w_go, w_tie, w_gnt, w_gnt_sel, w_gnt_drop;
    logic [AW-1:0] w_gnt_addr;
    logic [DW-1:0] w_gnt_data;

    logic          r_wr_en, r_wr_sel, r_last;
    logic [AW-1:0] r_wr_addr;
    logic [DW-1:0] r_wr_data;
    logic [15:0]   r_cnt;

    wb_req_buffer #(.AW(AW), .DW(DW)) u_buf0 (
        .clk(clk), .rst(rst),
        .i_valid(req0_valid), .i_addr(req0_addr), .i_data(req0_data),
        .o_ready(req0_ready), .i_flush(flush),
        .i_clear(w_gnt && (w_gnt_sel == c_SRC_ALU)),
        .o_full(w_full0), .o_addr(w_addr0), .o_data(w_data0)
    );

    wb_req_buffer #(.AW(AW), .DW(DW)) u_buf1 (
        .clk(clk), .rst(rst),
        .i_valid(req1_valid), .i_addr(req1_addr), .i_data(req1_data),
        .o_ready(req1_ready), .i_flush(flush),
        .i_clear(w_gnt && (w_gnt_sel == c_SRC_MEM)),
        .o_full(w_full1), .o_addr(w_addr1), .o_data(w_data1)
    );

    assign w_go  = !stall && !flush;
    assign w_tie = w_full0 && w_full1 && w_go;

    always_comb begin
        w_gnt     = 1'b0;
        w_gnt_sel = c_SRC_ALU;
        if (w_tie) begin
            w_gnt     = 1'b1;
            w_gnt_sel = (PRIORITY_MODE == c_PRIO_FIXED_MEM) ? c_SRC_MEM : ~r_last;
        end else if (w_go && w_full0) begin
            w_gnt     = 1'b1;
            w_gnt_sel = c_SRC_ALU;
        end else if (w_go && w_full1) begin
            w_gnt     = 1'b1;
            w_gnt_sel = c_SRC_MEM;
        end
    end

    assign w_gnt_addr = (w_gnt_sel == c_SRC_MEM) ? w_addr1 : w_addr0;
    assign w_gnt_data = (w_gnt_sel == c_SRC_MEM) ? w_data1 : w_data0;
    // $zero writes are consumed from the buffer but never strobe the port.
    assign w_gnt_drop = (ZERO_DISCARD != 0) && (w_gnt_addr == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wr_sel  <= 1'b0;
            r_last    <= 1'b1;
            r_cnt     <= '0;
        end else begin
            r_wr_en <= w_gnt && !w_gnt_drop;
            if (w_gnt) begin
                r_wr_addr <= w_gnt_addr;
                r_wr_data <= w_gnt_data;
                r_wr_sel  <= w_gnt_sel;
            end
            if (w_tie && (PRIORITY_MODE == c_PRIO_RR)) begin
                r_last <= w_gnt_sel;
            end
            if (w_tie && (r_cnt != 16'hFFFF)) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign wr_en        = r_wr_en;
    assign wr_addr      = r_wr_addr;
    assign wr_data      = r_wr_data;
    assign wr_sel       = r_wr_sel;
    assign conflict_cnt = r_cnt;
endmodule

`default_nettype wire
